npc_mc_core: RTL
================

Name: npc_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle addi-only datapath in npc top.
- Fetches instructions over a valid/response handshake and executes a small RV32I/RV32E subset: addi, add, lui, auipc, jal, jalr, ebreak.
- Writes results to an internal register file and halts on ebreak or an illegal instruction.
- Sits between the simulation memory model (instruction port) and the difftest/commit monitor.

Parameters:
- XLEN, 32, datapath and register width; legal values 32 or 64.
- RESET_PC, 32'h80000000, pc value after reset, zero-extended to XLEN.
- NR_REGS, 32, register count; 32 gives RV32I, 16 gives RV32E.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ifu_req_valid  output  1  fetch request; high only in state FETCH.
- ifu_req_addr  output  XLEN  fetch address, equal to pc.
- ifu_rsp_valid  input  1  instruction valid; sampled only while ifu_req_valid=1.
- ifu_rsp_inst  input  32  instruction word.
- commit_valid  output  1  one-cycle pulse per retired instruction.
- commit_pc  output  XLEN  pc of the retired instruction.
- commit_inst  output  32  retired instruction word.
- halt  output  1  sticky; core is stopped.
- halt_bad  output  1  halt was caused by an illegal instruction.
- halt_code  output  XLEN  value of x10 (a0) at halt.

Behaviour:
- Reset takes effect at the next rising edge and overrides everything, including a reset that arrives mid-fetch.
- Values after reset:
  - pc=RESET_PC, state=FETCH.
  - All regs=0.
  - commit_valid=0, halt=0, halt_bad=0, halt_code=0.
  - ifu_req_valid=1 in the first cycle after reset.
- State FETCH:
  - Hold ifu_req_valid=1 and ifu_req_addr=pc.
  - On ifu_rsp_valid=1, latch inst and go to EXEC.
  - Otherwise stay; unbounded wait.
  - A response in the same cycle as the request is accepted (zero-wait memory).
- State EXEC (one cycle): decode, compute, write rd, update pc, pulse commit_valid with the latched pc/inst, then go to FETCH.
- Minimum throughput: 2 cycles per instruction.
- State HALT: terminal; ifu_req_valid=0, commit_valid=0, regs frozen; only reset leaves it.
- Decode rules (all immediates sign-extended to XLEN, using bit 31 of the instruction):
  - addi: opcode 0010011, funct3 000. rd = rs1 + imm[31:20].
  - add: opcode 0110011, funct3 000, funct7 0000000. rd = rs1 + rs2.
  - lui: rd = {imm[31:12], 12'b0}.
  - auipc: rd = pc + {imm[31:12], 12'b0}.
  - jal: rd = pc+4; pc = pc + J-imm.
  - jalr: rd = pc+4; pc = (rs1 + I-imm) & ~1. rs1 is read before rd is written, so jalr x1,0(x1) is correct.
  - ebreak (32'h00100073): retires with commit_valid=1, then HALT. halt_code = x10 as it reads in that EXEC cycle.
- Non-jump instructions: pc = pc+4.
- Arithmetic wraps modulo 2^XLEN; overflow is not flagged.
- Writes to x0 are discarded; x0 always reads 0.
- Illegal encoding:
  - Any other opcode, or a register index >= NR_REGS when NR_REGS=16.
  - No commit pulse, no register write.
  - Go to HALT with halt_bad=1 and halt_code = x10.
- Misaligned jump targets (pc[1]=1) are not trapped; the next fetch simply uses that address.

Optional Feature:
- Macro NPC_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt, 64 bits.
  - Reset to 0; +1 on every commit_valid pulse, including ebreak.
  - Wraps at 2^64; frozen in HALT.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package npc_pkg:
  - Opcode constants: OP_IMM, OP, LUI, AUIPC, JAL, JALR, SYSTEM.
  - Constant EBREAK_INST.
  - State enum: FETCH, EXEC, HALT.
  - Immediate-type enum: I, U, J.
- Sub-module npc_regfile, parameters XLEN and NR_REGS:
  - Two asynchronous read ports, one synchronous write port with enable.
  - x0 hardwired to zero; synchronous reset clears all entries.

Test Plan:
- Reset, then addi x1,x0,-1 (32'hfff00093) with zero-wait response -> commit_valid in cycle 2, commit_pc=80000000, x1=ffffffff, pc=80000004.
- Delay ifu_rsp_valid 5 cycles -> ifu_req_valid held for 6 cycles with addr stable, no commit pulses; exactly one commit after the response.
- Sequence lui x10,0x12345; addi x10,x10,0x678; ebreak -> halt=1, halt_bad=0, halt_code=12345678; 3 commits, none afterwards.
- jal x1,+8 at 80000000 -> x1=80000004, next ifu_req_addr=80000008. Then jalr x0,0(x1) -> next addr 80000004.
- Opcode 7'b1111111 -> no commit, halt=1, halt_bad=1. Then assert reset for one cycle -> pc=80000000, halt=0, fetching resumes.
- Assert reset while waiting in FETCH, with the response arriving the same cycle -> response ignored, pc=80000000. With NPC_RETIRE_CNT_EN defined, retire_cnt=0 after reset and equals 3 after the ebreak sequence.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared opcodes, FSM states, immediate types and immediate decoding for npc_mc_core.
// No ports; imported by npc_mc_core.
package npc_pkg;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;
    typedef enum logic [1:0] {I, U, J} imm_e;
    // Returns the 32-bit sign-extended immediate of the given format.
    function automatic logic [31:0] imm_ext(input logic [31:0] inst, input imm_e t);
        return t == U ? {inst[31:12], 12'b0} :
               t == J ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
                        {{20{inst[31]}}, inst[31:20]};
    endfunction
endpackage

// File: rtl/npc_mc_core_if.sv
// npc_mc_core_if: instruction-fetch handshake and commit monitor bus of npc_mc_core.
// Signals: ifu_req_valid/ifu_req_addr (core->mem), ifu_rsp_valid/ifu_rsp_inst (mem->core),
//          commit_valid/commit_pc/commit_inst (core->monitor).
// Modports: master = core side, slave = memory/monitor side.
interface npc_mc_core_if #(parameter int XLEN = 32);
    logic            ifu_req_valid;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_rsp_valid;
    logic [31:0]     ifu_rsp_inst;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_inst;
    modport master (output ifu_req_valid, ifu_req_addr, commit_valid, commit_pc, commit_inst,
                    input ifu_rsp_valid, ifu_rsp_inst);
    modport slave (input ifu_req_valid, ifu_req_addr, commit_valid, commit_pc, commit_inst,
                   output ifu_rsp_valid, ifu_rsp_inst);
endinterface

// File: rtl/npc_regfile.sv
// npc_regfile: NR_REGS x XLEN register file, x0 hardwired to zero.
// Ports: clk, reset (sync, active-high, clears all entries); ra1/ra2 -> rdata1/rdata2 (async reads);
//        we/wa/wd (sync write, writes to x0 dropped).
module npc_regfile #(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    localparam int AW = $clog2(NR_REGS);
    logic [XLEN-1:0] regs_q [NR_REGS];
    logic [XLEN-1:0] regs_d [NR_REGS];
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wa[AW-1:0]] = wd;
        regs_d[0] = '0;
    end
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end
    assign rdata1 = regs_q[ra1[AW-1:0]];
    assign rdata2 = regs_q[ra2[AW-1:0]];
endmodule

// File: rtl/npc_mc_core.sv
// npc_mc_core: multi-cycle RV32I/RV32E subset core (addi, add, lui, auipc, jal, jalr, ebreak).
// Ports: clk, reset (sync, active-high); bus (npc_mc_core_if.master: fetch handshake + commit);
//        halt (sticky), halt_bad (illegal instruction), halt_code (x10 at halt);
//        retire_cnt (64-bit retired-instruction count, only with NPC_RETIRE_CNT_EN defined).
module npc_mc_core
    import npc_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NR_REGS  = 32
) (
    input  logic            clk,
    input  logic            reset,
    npc_mc_core_if.master   bus,
    output logic            halt,
    output logic            halt_bad,
    output logic [XLEN-1:0] halt_code
`ifdef NPC_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt
`endif
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, halt_code_q, halt_code_d;
    logic [31:0]     inst_q, inst_d;
    logic            halt_bad_q, halt_bad_d;
    logic [6:0]      opc;
    logic [4:0]      rd, rs1, rs2, ra1;
    logic            is_addi, is_add, is_lui, is_auipc, is_jal, is_jalr, is_ebreak;
    logic            bad_reg, legal, exec, we;
    logic [XLEN-1:0] rs1_v, rs2_v, imm, pc4, sum_pc, sum_rs, wd;
    assign opc       = inst_q[6:0];
    assign rd        = inst_q[11:7];
    assign rs1       = inst_q[19:15];
    assign rs2       = inst_q[24:20];
    assign is_addi   = opc == OP_IMM && inst_q[14:12] == 3'b000;
    assign is_add    = opc == OP && inst_q[14:12] == 3'b000 && inst_q[31:25] == 7'b0;
    assign is_lui    = opc == LUI;
    assign is_auipc  = opc == AUIPC;
    assign is_jal    = opc == JAL;
    assign is_jalr   = opc == JALR;
    assign is_ebreak = opc == SYSTEM && inst_q == EBREAK_INST;
    // RV32E only has x0..x15: any referenced index with bit 4 set is illegal.
    assign bad_reg = NR_REGS == 16 && (rd[4] || (rs1[4] && (is_addi || is_add || is_jalr)) || (rs2[4] && is_add));
    assign legal   = (is_addi || is_add || is_lui || is_auipc || is_jal || is_jalr || is_ebreak) && !bad_reg;
    assign exec    = state_q == EXEC;
    assign we      = exec && legal && !is_ebreak;
    // On a halting instruction port 1 is steered to x10 so halt_code is captured without a third read port.
    assign ra1     = (is_ebreak || !legal) ? 5'd10 : rs1;
    assign imm     = XLEN'(signed'(imm_ext(inst_q, (is_lui || is_auipc) ? U : is_jal ? J : I)));
    assign pc4     = pc_q + XLEN'(4);
    assign sum_pc  = pc_q + imm;
    assign sum_rs  = rs1_v + (is_add ? rs2_v : imm);
    assign wd      = is_lui ? imm : is_auipc ? sum_pc : (is_jal || is_jalr) ? pc4 : sum_rs;
    npc_regfile #(.XLEN(XLEN), .NR_REGS(NR_REGS)) u_rf (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(rs2), .we(we), .wa(rd), .wd(wd),
        .rdata1(rs1_v), .rdata2(rs2_v)
    );
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        halt_bad_d  = halt_bad_q;
        halt_code_d = halt_code_q;
        if (state_q == FETCH && bus.ifu_rsp_valid) begin
            inst_d  = bus.ifu_rsp_inst;
            state_d = EXEC;
        end
        if (exec) begin
            state_d     = (legal && !is_ebreak) ? FETCH : HALT;
            pc_d        = !legal ? pc_q : is_jal ? sum_pc : is_jalr ? (sum_rs & ~XLEN'(1)) : pc4;
            halt_bad_d  = !legal;
            halt_code_d = (legal && !is_ebreak) ? halt_code_q : rs1_v;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= XLEN'(RESET_PC);
            inst_q      <= '0;
            halt_bad_q  <= 1'b0;
            halt_code_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            halt_bad_q  <= halt_bad_d;
            halt_code_q <= halt_code_d;
        end
    end
    assign bus.ifu_req_valid = state_q == FETCH;
    assign bus.ifu_req_addr  = pc_q;
    assign bus.commit_valid  = exec && legal;
    assign bus.commit_pc     = pc_q;
    assign bus.commit_inst   = inst_q;
    assign halt              = state_q == HALT;
    assign halt_bad          = halt_bad_q;
    assign halt_code         = halt_code_q;
`ifdef NPC_RETIRE_CNT_EN
    logic [63:0] cnt_q, cnt_d;
    assign cnt_d = cnt_q + 64'(bus.commit_valid);
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign retire_cnt = cnt_q;
`endif
endmodule
